pc_sequencer: RTL
=================

Name: pc_sequencer

Overview:
- Control sequencer for the program-counter datapath: PCL/PCH select muxes, incrementers and registers.
- Accepts one high-level PC command per handshake (increment, load, push, relative branch).
- Drives the per-cycle select/increment/bus-enable strobes for the low and high PC halves.
- Sits between the instruction decoder/timing logic and the PC datapath; guarantees legal (mutually exclusive) select combinations every cycle.

Parameters:
- CMD_W, 3, width of cmd input.

Ports:
- phi_2  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command request.
- cmd  input  CMD_W  command code: 0 NOP, 1 INC, 2 LOAD, 3 PUSH, 4 BRANCH; 5-7 illegal.
- cmd_ready  output  1  command accepted on edge where cmd_valid & cmd_ready.
- page_cross  input  1  ALU branch-target carry/borrow into PCH, sampled in the BR_LO step.
- pcl_pcl  output  1  PCL select: recirculate PCL.
- adl_pcl  output  1  PCL select: load from ADL bus.
- pch_pch  output  1  PCH select: recirculate PCH.
- adh_pch  output  1  PCH select: load from ADH bus.
- i_pc  output  1  increment enable into PCL incrementer.
- pcl_db  output  1  drive PCL onto DB.
- pcl_adl  output  1  drive PCL onto ADL.
- pch_db  output  1  drive PCH onto DB.
- pch_adh  output  1  drive PCH onto ADH.
- done  output  1  one-cycle pulse in the final step of a command.
- illegal_cmd  output  1  one-cycle pulse after accepting codes 5-7.

Behaviour:
- States: IDLE, INC, LOAD, PUSH_H, PUSH_L, BR_LO, BR_FIX.
- All strobe outputs are registered; a command accepted at edge E drives its first step in the cycle following E.
- Hold word (IDLE, and all outputs after reset): pcl_pcl=1, pch_pch=1; all other strobes 0; done=0; illegal_cmd=0.
- Invariant, every cycle: exactly one of pcl_pcl/adl_pcl is 1 and exactly one of pch_pch/adh_pch is 1. The verification bench asserts this continuously.
- INC (1 step): pcl_pcl=1, pch_pch=1, i_pc=1, pcl_adl=1, pch_adh=1, done=1.
- LOAD (1 step): adl_pcl=1, adh_pch=1, i_pc=0, done=1. Used for jump and vector fetch.
- PUSH (2 steps): PUSH_H drives pch_db=1 with the hold selects; PUSH_L drives pcl_db=1 with the hold selects and done=1. i_pc=0 throughout.
- BRANCH, step BR_LO: adl_pcl=1, pch_pch=1, i_pc=0.
  - page_cross=0 at the end of BR_LO: done=1 in BR_LO and the command ends.
  - page_cross=1 at the end of BR_LO: go to BR_FIX (pcl_pcl=1, adh_pch=1, done=1).
  - done is a registered function of state plus the combinational page_cross in BR_LO.
- cmd_ready = (state==IDLE) | last_step, where last_step = INC | LOAD | PUSH_L | BR_FIX | (BR_LO & ~page_cross). cmd_ready is combinational and is never asserted in PUSH_H.
- Back-to-back: a command accepted during a last step starts its first step in the next cycle, with no IDLE gap.
- Sustained INC therefore gives one increment per cycle.
- No acceptance in a last step: return to IDLE (hold word) next cycle.
- NOP: accepted, no step, stays IDLE, no done.
- Illegal codes 5-7: treated as NOP; illegal_cmd pulses 1 cycle after acceptance.
- cmd_valid while not ready is ignored; the requester holds cmd stable until accepted.
- reset=1 at any edge, including mid-PUSH or mid-BRANCH:
  - next state IDLE, outputs become the hold word next cycle;
  - no done pulse, cmd_ready=0 while reset is high;
  - the in-flight command is abandoned.
- page_cross is ignored outside BR_LO.

Test Plan:
- Reset then idle: reset high 2 cycles, then low with cmd_valid=0 -> pcl_pcl=pch_pch=1, all other strobes 0, cmd_ready=1 from the first cycle after reset deasserts.
- INC streaming: cmd=1 with valid held 4 cycles -> i_pc, pcl_adl and pch_adh high 4 consecutive cycles starting 1 cycle after first acceptance; done high those 4 cycles; cmd_ready stays 1.
- PUSH: cmd=3 accepted -> cycle+1 pch_db=1 with cmd_ready=0; cycle+2 pcl_db=1 with done=1 and cmd_ready=1; neither bus enable overlaps the other.
- BRANCH without crossing: cmd=4, page_cross=0 -> single step adl_pcl=1, pch_pch=1, done=1. With crossing (page_cross=1) -> that step without done, followed by pcl_pcl=1, adh_pch=1, done=1.
- Reset mid-op: accept PUSH, assert reset during PUSH_H -> next cycle hold word, pcl_db never asserted, no done.
- Illegal/NOP: cmd=6 accepted -> illegal_cmd=1 next cycle, strobes stay at the hold word; cmd=0 -> no done, no illegal_cmd. Select-exclusivity assertion holds across all scenarios.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program-counter control sequencer: turns one PC command per handshake into per-cycle
// PCL/PCH select, increment and bus-enable strobes; strobes are registered, one step per cycle.
module pc_sequencer #(
  parameter int CMD_W = 3
) (
  input  logic             phi_2,
  input  logic             reset,
  input  logic             cmd_valid,
  input  logic [CMD_W-1:0] cmd,
  output logic             cmd_ready,
  input  logic             page_cross,
  output logic             pcl_pcl,
  output logic             adl_pcl,
  output logic             pch_pch,
  output logic             adh_pch,
  output logic             i_pc,
  output logic             pcl_db,
  output logic             pcl_adl,
  output logic             pch_db,
  output logic             pch_adh,
  output logic             done,
  output logic             illegal_cmd
);

  typedef enum logic [2:0] {
    S_IDLE, S_INC, S_LOAD, S_PUSH_H, S_PUSH_L, S_BR_LO, S_BR_FIX
  } state_t;

  localparam logic [CMD_W-1:0] C_INC    = CMD_W'(1);
  localparam logic [CMD_W-1:0] C_LOAD   = CMD_W'(2);
  localparam logic [CMD_W-1:0] C_PUSH   = CMD_W'(3);
  localparam logic [CMD_W-1:0] C_BRANCH = CMD_W'(4);

  // Strobe order: pcl_pcl adl_pcl pch_pch adh_pch i_pc pcl_db pcl_adl pch_db pch_adh
  localparam logic [8:0] W_HOLD   = 9'b1_0_1_0_0_0_0_0_0;
  localparam logic [8:0] W_INC    = 9'b1_0_1_0_1_0_1_0_1;
  localparam logic [8:0] W_LOAD   = 9'b0_1_0_1_0_0_0_0_0;
  localparam logic [8:0] W_PUSH_H = 9'b1_0_1_0_0_0_0_1_0;
  localparam logic [8:0] W_PUSH_L = 9'b1_0_1_0_0_1_0_0_0;
  localparam logic [8:0] W_BR_LO  = 9'b0_1_1_0_0_0_0_0_0;
  localparam logic [8:0] W_BR_FIX = 9'b1_0_0_1_0_0_0_0_0;

  state_t     state_q, state_d;
  logic [8:0] strb_q, strb_d;
  logic       done_q, done_d;
  logic       illegal_q, illegal_d;
  logic       last_step;
  logic       br_lo_done;

  always_comb begin
    state_d    = state_q;
    illegal_d  = 1'b0;
    strb_d     = W_HOLD;
    br_lo_done = (state_q == S_BR_LO) && !page_cross;
    last_step  = (state_q inside {S_INC, S_LOAD, S_PUSH_L, S_BR_FIX}) || br_lo_done;
    cmd_ready  = !reset && ((state_q == S_IDLE) || last_step);

    if (reset) begin
      state_d = S_IDLE;
    end else if ((state_q == S_IDLE) || last_step) begin
      state_d = S_IDLE;
      if (cmd_valid) begin
        case (cmd)
          C_INC:    state_d = S_INC;
          C_LOAD:   state_d = S_LOAD;
          C_PUSH:   state_d = S_PUSH_H;
          C_BRANCH: state_d = S_BR_LO;
          default:  illegal_d = (cmd > C_BRANCH);
        endcase
      end
    end else begin
      case (state_q)
        S_PUSH_H: state_d = S_PUSH_L;
        S_BR_LO:  state_d = S_BR_FIX;
        default:  state_d = S_IDLE;
      endcase
    end

    // Strobes for the step about to begin, so the outputs come straight from flops.
    case (state_d)
      S_INC:    strb_d = W_INC;
      S_LOAD:   strb_d = W_LOAD;
      S_PUSH_H: strb_d = W_PUSH_H;
      S_PUSH_L: strb_d = W_PUSH_L;
      S_BR_LO:  strb_d = W_BR_LO;
      S_BR_FIX: strb_d = W_BR_FIX;
      default:  strb_d = W_HOLD;
    endcase
    done_d = state_d inside {S_INC, S_LOAD, S_PUSH_L, S_BR_FIX};
  end

  always_ff @(posedge phi_2) begin
    if (reset) begin
      state_q   <= S_IDLE;
      strb_q    <= W_HOLD;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      strb_q    <= strb_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
    end
  end

  assign {pcl_pcl, adl_pcl, pch_pch, adh_pch, i_pc, pcl_db, pcl_adl, pch_db, pch_adh} = strb_q;
  // BR_LO only finishes the command when no page fix-up is needed; known within that cycle.
  assign done        = !reset && (done_q || br_lo_done);
  assign illegal_cmd = illegal_q;

endmodule
